centering_scheduler: RTL

Multi-channel sequencer for the whitening-stage centering datapath (accumulator, divider, subtractor, sample RAM). On one `GO` pulse it centers every channel in turn: clear sum, accumulate all samples, divide by sample count, then subtract the mean and write each sample back. It generates the datapath enables, the RAM read/write addresses and the channel select, and reports completion with `Busy`/`Done`.

---
 rtl/centering_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/centering_scheduler.sv
// rtl/centering_scheduler.sv - per-channel centering sequencer (clear, sum, divide, subtract/write-back)
// Optional divider watchdog and Err port: define CEN_TIMEOUT_EN.
module centering_scheduler #(
    parameter int SAMPLES  = 128,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 7,
    parameter int CH_W     = 2
) (
    input  logic              CLK_sch,
    input  logic              RST_sch,
    input  logic              GO,
    input  logic              DIV_valid,
    output logic              Busy,
    output logic              Done,
`ifdef CEN_TIMEOUT_EN
    output logic              Err,
`endif
    output logic              Clr_SUM,
    output logic              En_SUM,
    output logic              En_DIV,
    output logic              En_SUB,
    output logic [CH_W-1:0]   Ch_sel,
    output logic [ADDR_W-1:0] Rd_addr,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic              Wr_en
);

    localparam int CNT_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0] SUM_LAST = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0] SUB_LAST = CNT_W'(SAMPLES + 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_SUM, S_DIV, S_SUB, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CH_W-1:0]    ch_nxt;
    logic               busy_d, done_d, clr_d, en_sum_d, en_div_d, en_sub_d;
    logic [ADDR_W-1:0]  rd_d;
    logic               wr_en_p;
    logic [ADDR_W-1:0]  wr_addr_p;
`ifdef CEN_TIMEOUT_EN
    logic [5:0]         wd, wd_nxt;
    logic               err_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = Ch_sel;
`ifdef CEN_TIMEOUT_EN
        wd_nxt    = '0;
        err_nxt   = Err;
`endif
        case (state)
            S_IDLE: if (GO) begin
                state_nxt = S_CLR;
                ch_nxt    = '0;
`ifdef CEN_TIMEOUT_EN
                err_nxt   = 1'b0;
`endif
            end
            S_CLR: begin
                state_nxt = S_SUM;
                cnt_nxt   = '0;
            end
            S_SUM: begin
                if (cnt == SUM_LAST) begin
                    state_nxt = S_DIV;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (DIV_valid) begin
                    state_nxt = S_SUB;
                    cnt_nxt   = '0;
                end
`ifdef CEN_TIMEOUT_EN
                else if (wd == 6'd63) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd + 6'd1;
                end
`endif
            end
            S_SUB: begin
                if (cnt == SUB_LAST) begin
                    state_nxt = S_NEXT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_NEXT: begin
                if (Ch_sel == CH_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_CLR;
                    ch_nxt    = Ch_sel + CH_W'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        busy_d   = (state_nxt != S_IDLE);
        done_d   = (state_nxt == S_DONE);
        clr_d    = (state_nxt == S_CLR);
        en_sum_d = (state_nxt == S_SUM) && (cnt_nxt != '0);
        en_div_d = (state_nxt == S_DIV) && (state != S_DIV);
        en_sub_d = (state_nxt == S_SUB) && (cnt_nxt < SUM_LAST);
        rd_d     = ((state_nxt == S_SUM) || (state_nxt == S_SUB)) ? cnt_nxt[ADDR_W-1:0] : '0;
    end

    always_ff @(posedge CLK_sch or posedge RST_sch) begin
        if (RST_sch) begin
            state     <= S_IDLE;
            cnt       <= '0;
            Ch_sel    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Clr_SUM   <= 1'b0;
            En_SUM    <= 1'b0;
            En_DIV    <= 1'b0;
            En_SUB    <= 1'b0;
            Rd_addr   <= '0;
            wr_en_p   <= 1'b0;
            wr_addr_p <= '0;
            Wr_en     <= 1'b0;
            Wr_addr   <= '0;
`ifdef CEN_TIMEOUT_EN
            wd        <= '0;
            Err       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            Ch_sel    <= ch_nxt;
            Busy      <= busy_d;
            Done      <= done_d;
            Clr_SUM   <= clr_d;
            En_SUM    <= en_sum_d;
            En_DIV    <= en_div_d;
            En_SUB    <= en_sub_d;
            Rd_addr   <= rd_d;
            // Two-stage delay covers RAM read latency plus the registered subtractor.
            wr_en_p   <= En_SUB;
            wr_addr_p <= Rd_addr;
            Wr_en     <= wr_en_p;
            Wr_addr   <= wr_addr_p;
`ifdef CEN_TIMEOUT_EN
            wd        <= wd_nxt;
            Err       <= err_nxt;
`endif
        end
    end

endmodule
